cnn_layer_accel_fas_vec_sum_rdr: RTL



---
 rtl/cnn_layer_accel_fas_vec_sum_rdr_if.sv | 35 +++
 rtl/cnn_layer_accel_fas_vec_sum_rdr.sv | 130 +++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_fas_vec_sum_rdr_if.sv
// Bus bundle between the FAS vector-add stage, the vec-sum reader and the
// 1x1 conv input mux.
//   write channel : vec_sum_wr_en / vec_sum_din  -> reader, vec_sum_wr_rdy <- reader
//   replay channel: vec_sum_dout / vec_sum_valid / vec_sum_last_dpth /
//                   vec_sum_last_krnl <- reader, vec_sum_rdy -> reader
// Modports:
//   slave  : the reader block itself
//   master : the surrounding FAS logic (producer + consumer side)
interface cnn_layer_accel_fas_vec_sum_rdr_if #(
  parameter int PIXEL_WIDTH     = 16,
  parameter int VECTOR_ADD_SIMD = 8
);
  localparam int W = PIXEL_WIDTH * VECTOR_ADD_SIMD;

  logic         vec_sum_wr_en;
  logic [W-1:0] vec_sum_din;
  logic         vec_sum_wr_rdy;
  logic [W-1:0] vec_sum_dout;
  logic         vec_sum_valid;
  logic         vec_sum_rdy;
  logic         vec_sum_last_dpth;
  logic         vec_sum_last_krnl;

  modport slave (
    input  vec_sum_wr_en, vec_sum_din, vec_sum_rdy,
    output vec_sum_wr_rdy, vec_sum_dout, vec_sum_valid,
           vec_sum_last_dpth, vec_sum_last_krnl
  );

  modport master (
    output vec_sum_wr_en, vec_sum_din, vec_sum_rdy,
    input  vec_sum_wr_rdy, vec_sum_dout, vec_sum_valid,
           vec_sum_last_dpth, vec_sum_last_krnl
  );
endinterface

// File: rtl/cnn_layer_accel_fas_vec_sum_rdr.sv
// cnn_layer_accel_fas_vec_sum_rdr
// Captures one 1x1-kernel depth of SIMD vector sums, then replays that depth
// once per 1x1 kernel over a valid/ready channel.
// Ports:
//   clk_FAS                clock
//   rst_n                  synchronous active-low reset
//   process_cmpl           synchronous abort (buffer contents kept)
//   FAS_rdy_n              high = FAS not ready, synchronous abort
//   krnl1x1_dpth_end_cfg   last buffer index of a depth (clamped to ARR_SZ-1)
//   krnl1x1_cnt_end_cfg    last kernel index
//   vs                     write + replay channels (interface, slave side)
//   busy                   high when replaying or a partial depth is held
// Optional feature: define FAS_VEC_SUM_RDR_RELU_EN to clamp negative lanes of
// the replayed data to zero (applied in front of the dout register).
module cnn_layer_accel_fas_vec_sum_rdr #(
  parameter int PIXEL_WIDTH        = 16,
  parameter int VECTOR_ADD_SIMD    = 8,
  parameter int MAX_1X1_KRNL_DEPTH = 512
) (
  input  logic        clk_FAS,
  input  logic        rst_n,
  input  logic        process_cmpl,
  input  logic        FAS_rdy_n,
  input  logic [15:0] krnl1x1_dpth_end_cfg,
  input  logic [15:0] krnl1x1_cnt_end_cfg,
  cnn_layer_accel_fas_vec_sum_rdr_if.slave vs,
  output logic        busy
);
  localparam int ARR_SZ = MAX_1X1_KRNL_DEPTH / VECTOR_ADD_SIMD;
  localparam int AW     = (ARR_SZ > 1) ? $clog2(ARR_SZ) : 1;
  localparam logic [15:0] ARR_LAST = 16'(ARR_SZ - 1);

  typedef logic [VECTOR_ADD_SIMD-1:0][PIXEL_WIDTH-1:0] vec_t;
  typedef enum logic {FILL, REPLAY} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_addr_q, rd_addr_q, nxt_rd_addr, dpth_end;
  logic [15:0]   krnl_cnt_q, nxt_krnl_cnt;
  logic          valid_q;
  vec_t          dout_q, rd_raw, rd_word;
  vec_t          mem [ARR_SZ];

  logic abort, wr_fire, wr_last, hs, at_dend, at_kend, final_hs;
  logic [AW-1:0] ld_addr;

  // Oversized depth configs saturate to the buffer size.
  assign dpth_end = (krnl1x1_dpth_end_cfg > ARR_LAST) ? AW'(ARR_LAST)
                                                     : krnl1x1_dpth_end_cfg[AW-1:0];

  assign abort    = !rst_n || FAS_rdy_n || process_cmpl;
  assign wr_fire  = (state_q == FILL) && vs.vec_sum_wr_en;
  assign wr_last  = (wr_addr_q == dpth_end);
  assign hs       = valid_q && vs.vec_sum_rdy;
  assign at_dend  = (rd_addr_q == dpth_end);
  assign at_kend  = (krnl_cnt_q == krnl1x1_cnt_end_cfg);
  assign final_hs = hs && at_dend && at_kend;

  // rd_addr/krnl_cnt always name the entry sitting in dout; the next entry is
  // fetched in the handshake cycle so the stream has no bubbles at wraps.
  always_comb begin
    nxt_rd_addr  = at_dend ? '0 : rd_addr_q + AW'(1);
    nxt_krnl_cnt = at_dend ? krnl_cnt_q + 16'd1 : krnl_cnt_q;
    ld_addr      = valid_q ? nxt_rd_addr : rd_addr_q;
  end

  assign rd_raw = mem[ld_addr];

  for (genvar l = 0; l < VECTOR_ADD_SIMD; l++) begin : g_lane
`ifdef FAS_VEC_SUM_RDR_RELU_EN
    assign rd_word[l] = rd_raw[l][PIXEL_WIDTH-1] ? '0 : rd_raw[l];
`else
    assign rd_word[l] = rd_raw[l];
`endif
  end

  always_comb begin
    state_d = state_q;
    if (abort) state_d = FILL;
    else begin
      case (state_q)
        FILL:    if (wr_fire && wr_last) state_d = REPLAY;
        REPLAY:  if (final_hs)           state_d = FILL;
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk_FAS) begin
    if (abort) begin
      state_q    <= FILL;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      krnl_cnt_q <= '0;
      valid_q    <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q <= state_d;
      if (wr_fire) wr_addr_q <= wr_last ? '0 : wr_addr_q + AW'(1);
      if (state_q == REPLAY) begin
        if (!valid_q) begin
          // first beat after the fill completes
          valid_q <= 1'b1;
          dout_q  <= rd_word;
        end else if (vs.vec_sum_rdy) begin
          if (final_hs) begin
            valid_q    <= 1'b0;
            rd_addr_q  <= '0;
            krnl_cnt_q <= '0;
          end else begin
            rd_addr_q  <= nxt_rd_addr;
            krnl_cnt_q <= nxt_krnl_cnt;
            dout_q     <= rd_word;
          end
        end
      end
    end
  end

  // Buffer has no reset; aborts leave the contents in place.
  always_ff @(posedge clk_FAS) begin
    if (wr_fire && !abort) mem[wr_addr_q] <= vs.vec_sum_din;
  end

  assign vs.vec_sum_wr_rdy    = (state_q == FILL);
  assign vs.vec_sum_dout      = dout_q;
  assign vs.vec_sum_valid     = valid_q;
  assign vs.vec_sum_last_dpth = valid_q && at_dend;
  assign vs.vec_sum_last_krnl = valid_q && at_kend;
  assign busy                 = (state_q != FILL) || (wr_addr_q != '0);
endmodule
